window_3x3_buffer: RTL and testbench

Streaming 3x3 window generator that sits directly upstream of the horizontal and vertical Sobel edge-detect stages. It accepts one 10-bit intensity pixel per valid cycle in raster order from the intensity-calculation stage. Two on-chip line buffers hold the previous two image rows. It emits the packed 90-bit neighbourhood grid those stages consume, plus the centre-pixel coordinates, only for windows that lie entirely inside the image.

---
 rtl/window_3x3_buffer.sv | 120 ++++++++++++
 tb/tb_window_3x3_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_buffer.sv
// Streaming 3x3 neighbourhood generator: two column-indexed line buffers feed a
// 3x3 shift window; only windows lying fully inside the image are flagged valid.
module window_3x3_buffer #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  iPixel,
    input  logic        iValid,
    input  logic        iSOF,
    output logic [89:0] oGrid,
    output logic        oValid,
    output logic [10:0] oCol,
    output logic [10:0] oRow
);

    localparam int unsigned PW = 10;
    localparam int unsigned CW = 11;
    localparam int unsigned AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col, row;
    logic [CW-1:0] cur_col, cur_row;
    logic [AW-1:0] addr;

    // iSOF forces the accepted pixel to (0,0) regardless of counter state
    always_comb begin
        cur_col = iSOF ? '0 : col;
        cur_row = iSOF ? '0 : row;
        addr    = AW'(cur_col);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (iValid) begin
            if (cur_col == LAST_COL) begin
                col <= '0;
                row <= (cur_row == LAST_ROW) ? '0 : cur_row + CW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    // Line buffers: A = row r-1, B = row r-2; read-before-write, never cleared
    logic [PW-1:0] line_a [IMG_WIDTH];
    logic [PW-1:0] line_b [IMG_WIDTH];
    logic [PW-1:0] tap_a, tap_b;

    always_ff @(posedge clock) begin
        if (iValid && !reset) begin
            tap_a        <= line_a[addr];
            tap_b        <= line_b[addr];
            line_a[addr] <= iPixel;
            line_b[addr] <= line_a[addr];
        end
    end

    logic          s1_valid, s1_qual;
    logic [CW-1:0] s1_col, s1_row;
    logic [PW-1:0] s1_pix;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_qual  <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_pix   <= '0;
        end else begin
            s1_valid <= iValid;
            if (iValid) begin
                s1_qual <= (cur_col >= CW'(2)) && (cur_row >= CW'(2));
                s1_col  <= cur_col;
                s1_row  <= cur_row;
                s1_pix  <= iPixel;
            end
        end
    end

    // Column shift registers, index 0 = most recent column
    logic [1:0][PW-1:0] top, mid, bot;
    logic [89:0]        grid_c;

    always_comb begin
        grid_c = {top[1], top[0], tap_b,
                  mid[1], mid[0], tap_a,
                  bot[1], bot[0], s1_pix};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            top    <= '0;
            mid    <= '0;
            bot    <= '0;
            oValid <= 1'b0;
            oGrid  <= '0;
            oCol   <= '0;
            oRow   <= '0;
        end else begin
            oValid <= s1_valid && s1_qual;
            if (s1_valid) begin
                top <= {top[0], tap_b};
                mid <= {mid[0], tap_a};
                bot <= {bot[0], s1_pix};
            end
            if (s1_valid && s1_qual) begin
                oGrid <= grid_c;
                oCol  <= s1_col - CW'(1);
                oRow  <= s1_row - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_buffer.sv
// Scoreboard bench for window_3x3_buffer: a small 5x4 instance for the directed
// scenarios and a 640-wide instance for the wide-line corner.
module tb_window_3x3_buffer;

    localparam int W0 = 5;
    localparam int H0 = 4;
    localparam int W1 = 640;
    localparam int H1 = 40;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [9:0]  px0 = '0, px1 = '0;
    logic        vl0 = 1'b0, vl1 = 1'b0, sf0 = 1'b0, sf1 = 1'b0;
    logic        rs0 = 1'b1, rs1 = 1'b1;
    logic [89:0] og0, og1;
    logic        ov0, ov1;
    logic [10:0] oc0, oc1, or0, or1;

    window_3x3_buffer #(.IMG_WIDTH(W0), .IMG_HEIGHT(H0)) u_small (
        .clock(clock), .reset(rs0), .iPixel(px0), .iValid(vl0), .iSOF(sf0),
        .oGrid(og0), .oValid(ov0), .oCol(oc0), .oRow(or0));

    window_3x3_buffer #(.IMG_WIDTH(W1), .IMG_HEIGHT(H1)) u_wide (
        .clock(clock), .reset(rs1), .iPixel(px1), .iValid(vl1), .iSOF(sf1),
        .oGrid(og1), .oValid(ov1), .oCol(oc1), .oRow(or1));

    typedef struct {
        logic [89:0] g;
        logic [10:0] c;
        logic [10:0] r;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [9:0] img [2][H1][W1];
    int mr[2], mc[2];
    int pulses[2];
    int lastc = 0, lastr = 0;
    int cyc = 0;
    int compared = 0, mismatched = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, req);
        end
    endtask

    // Reference: the image as a 2-D array; each interior pixel yields its 3x3 neighbourhood
    task automatic model(input int d, input logic [9:0] pix, input logic v, input logic sof, input logic rst);
        int w, h, r, c;
        exp_t e;
        w = (d == 0) ? W0 : W1;
        h = (d == 0) ? H0 : H1;
        if (rst) begin
            mr[d] = 0;
            mc[d] = 0;
            if (d == 0) begin
                while (q0.size() > 0 && q0[$].cyc > cyc) void'(q0.pop_back());
            end else begin
                while (q1.size() > 0 && q1[$].cyc > cyc) void'(q1.pop_back());
            end
        end else if (v) begin
            r = sof ? 0 : mr[d];
            c = sof ? 0 : mc[d];
            img[d][r][c] = pix;
            if (r >= 2 && c >= 2) begin
                e.g = '0;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        e.g[10*(8-(3*dr+dc)) +: 10] = img[d][r-2+dr][c-2+dc];
                e.c   = 11'(c - 1);
                e.r   = 11'(r - 1);
                e.cyc = cyc + 2;
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (c == w - 1) begin
                mc[d] = 0;
                mr[d] = (r == h - 1) ? 0 : r + 1;
            end else begin
                mc[d] = c + 1;
                mr[d] = r;
            end
        end
    endtask

    task automatic drive(input int d, input logic [9:0] pix, input logic v, input logic sof, input logic rst);
        @(posedge clock);
        #1;
        if (d == 0) begin
            px0 = pix; vl0 = v; sf0 = sof; rs0 = rst;
        end else begin
            px1 = pix; vl1 = v; sf1 = sof; rs1 = rst;
        end
        model(d, pix, v, sof, rst);
    endtask

    task automatic idle(input int d);
        drive(d, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int d);
        repeat (4) idle(d);
    endtask

    task automatic send_frame(input int d, input logic sof, input int gap, input bit rnd);
        int w, h;
        logic [9:0] pix;
        w = (d == 0) ? W0 : W1;
        h = (d == 0) ? H0 : H1;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                pix = rnd ? 10'($urandom) : 10'(10 * r + c);
                drive(d, pix, 1'b1, sof && r == 0 && c == 0, 1'b0);
                if (gap == 1) idle(d);
                if (gap == 2 && $urandom_range(0, 3) == 0) idle(d);
            end
        end
    endtask

    task automatic send_prefix(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 10'(10 * (i / W0) + (i % W0)), 1'b1, i == 0, 1'b0);
    endtask

    task automatic mon(input int d);
        exp_t e;
        logic v;
        logic [89:0] g;
        logic [10:0] c, r;
        int n;
        v = (d == 0) ? ov0 : ov1;
        g = (d == 0) ? og0 : og1;
        c = (d == 0) ? oc0 : oc1;
        r = (d == 0) ? or0 : or1;
        n = (d == 0) ? q0.size() : q1.size();
        if (n > 0) begin
            e = (d == 0) ? q0[0] : q1[0];
            if (e.cyc < cyc) begin
                check($sformatf("missed_window%0d", d), 128'(cyc), 128'(e.cyc));
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
        if (v) begin
            pulses[d]++;
            if (d == 1) begin
                lastc = int'(c);
                lastr = int'(r);
            end
            n = (d == 0) ? q0.size() : q1.size();
            if (n == 0) begin
                check($sformatf("unexpected_valid%0d", d), 128'(1), 128'(0));
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("latency%0d", d), 128'(cyc), 128'(e.cyc));
                check($sformatf("grid%0d", d), 128'(g), 128'(e.g));
                check($sformatf("col%0d", d), 128'(c), 128'(e.c));
                check($sformatf("row%0d", d), 128'(r), 128'(e.r));
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0);
        mon(1);
    end

    int p;

    initial begin
        mr[0] = 0; mc[0] = 0; mr[1] = 0; mc[1] = 0;
        pulses[0] = 0; pulses[1] = 0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 128'({ov0, ov1}), 128'(0));
        check("rst_grid", 128'(og0 | og1), 128'(0));
        check("rst_colrow", 128'({oc0, or0, oc1, or1}), 128'(0));
        rs0 = 1'b0;
        rs1 = 1'b0;

        p = pulses[0]; send_frame(0, 1'b1, 0, 1'b0); drain(0);
        check("basic_pulses", 128'(pulses[0] - p), 128'(6));

        p = pulses[0]; send_frame(0, 1'b1, 1, 1'b0); drain(0);
        check("bubble_pulses", 128'(pulses[0] - p), 128'(6));

        p = pulses[0]; send_frame(0, 1'b1, 0, 1'b0); send_frame(0, 1'b0, 0, 1'b0); drain(0);
        check("wrap_pulses", 128'(pulses[0] - p), 128'(12));

        p = pulses[0]; send_prefix(2 * W0 + 3); send_frame(0, 1'b1, 0, 1'b0); drain(0);
        check("midsof_pulses", 128'(pulses[0] - p), 128'(7));

        p = pulses[0]; send_prefix(3 * W0 + 1);
        drive(0, 10'h3ff, 1'b1, 1'b1, 1'b1);
        idle(0);
        check("postrst_valid", 128'(ov0), 128'(0));
        check("postrst_grid", 128'(og0), 128'(0));
        check("postrst_colrow", 128'({oc0, or0}), 128'(0));
        send_frame(0, 1'b0, 0, 1'b0); drain(0);
        check("reset_pulses", 128'(pulses[0] - p), 128'(9));

        p = pulses[0];
        repeat (3) send_frame(0, 1'b0, 2, 1'b1);
        drain(0);
        check("random_pulses", 128'(pulses[0] - p), 128'(18));

        p = pulses[1]; send_frame(1, 1'b1, 0, 1'b1); drain(1);
        check("wide_pulses", 128'(pulses[1] - p), 128'((W1 - 2) * (H1 - 2)));
        check("wide_last_col", 128'(lastc), 128'(W1 - 2));
        check("wide_last_row", 128'(lastr), 128'(H1 - 2));

        check("queue0_empty", 128'(q0.size()), 128'(0));
        check("queue1_empty", 128'(q1.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
